// File: rtl/prbs7_pkg.sv
// Shared constants, state type and feedback function for the PRBS-7 (x^7+x^3+1) checker.
package prbs7_pkg;

  localparam int PRBS_W = 7;
  localparam int TAP_A  = 6;
  localparam int TAP_B  = 2;

  typedef enum logic [1:0] {
    SEED,
    VERIFY,
    LOCKED
  } state_t;

  function automatic logic prbs7_fb(input logic [PRBS_W-1:0] hist);
    return hist[TAP_A] ^ hist[TAP_B];
  endfunction

endpackage

// File: rtl/prbs7_checker_if.sv
// Serial pattern input and lock/error status bundle of the PRBS-7 checker.
interface prbs7_checker_if #(
  parameter int CNT_W = 16
);

  logic             en;
  logic             bit_in;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  modport master (
    output en, bit_in, clr_cnt,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  en, bit_in, clr_cnt,
    output locked, err_pulse, err_count
  );

endinterface

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS-7 receiver: seeds from the stream, verifies, then free-runs
// a local copy while counting bit errors.
module prbs7_checker
  import prbs7_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  prbs7_checker_if.slave link
);

  state_t              state_q, state_d;
  logic [PRBS_W-1:0]   hist_q, hist_d, hist_shift;
  logic [2:0]          seed_cnt_q, seed_cnt_d;
  logic [7:0]          ok_cnt_q, ok_cnt_d;
  logic [3:0]          bad_run_q, bad_run_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic                pred;
  logic                match;

  assign pred       = prbs7_fb(hist_q);
  assign match      = (link.bit_in == pred);
  assign hist_shift = {hist_q[PRBS_W-2:0], link.bit_in};

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    seed_cnt_d  = seed_cnt_q;
    ok_cnt_d    = ok_cnt_q;
    bad_run_d   = bad_run_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;

    if (link.en) begin
      case (state_q)
        SEED: begin
          hist_d     = hist_shift;
          seed_cnt_d = seed_cnt_q + 3'd1;
          if (seed_cnt_d == 3'(PRBS_W)) begin
            state_d  = VERIFY;
            ok_cnt_d = '0;
          end
        end
        VERIFY: begin
          hist_d = hist_shift;
          // An all-zero history also predicts zero, so it must never count toward lock.
          if (match && (hist_shift != '0)) begin
            ok_cnt_d = ok_cnt_q + 8'd1;
            if (ok_cnt_d == 8'(LOCK_CNT)) begin
              state_d   = LOCKED;
              bad_run_d = '0;
            end
          end else begin
            ok_cnt_d = '0;
          end
        end
        LOCKED: begin
          hist_d = {hist_q[PRBS_W-2:0], pred};
          if (!match) begin
            err_pulse_d = 1'b1;
            bad_run_d   = bad_run_q + 4'd1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
            if (bad_run_d == 4'(LOSS_CNT)) begin
              state_d    = SEED;
              seed_cnt_d = '0;
              ok_cnt_d   = '0;
            end
          end else begin
            bad_run_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
    end

    if (link.clr_cnt) begin
      err_count_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEED;
      hist_q      <= '0;
      seed_cnt_q  <= '0;
      ok_cnt_q    <= '0;
      bad_run_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      seed_cnt_q  <= seed_cnt_d;
      ok_cnt_q    <= ok_cnt_d;
      bad_run_q   <= bad_run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign link.locked    = locked_q;
  assign link.err_pulse = err_pulse_q;
  assign link.err_count = err_count_q;

endmodule
